// File: rtl/uba_intack.sv
// uba_intack: UBA interrupt-acknowledge arbiter; grants one device request and returns its vector
//   busACKI/busPI         : CPU vector-read request and PI level being acknowledged
//   statPIH/statPIL       : PI levels assigned to BR7/BR6 and BR5/BR4 requests
//   devINTR/devACKO       : per-device BR7..BR4 requests and one-hot grant
//   devVECTV/devVECT      : per-device vector strobe and vector
//   busACKO/busVECT/busTMO: completion pulse, returned vector, no-vector timeout flag
module uba_intack #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busACKI,
  input  logic [2:0]  busPI,
  input  logic [2:0]  statPIH,
  input  logic [2:0]  statPIL,
  input  logic [7:4]  devINTR  [1:4],
  output logic [7:4]  devACKO  [1:4],
  input  logic        devVECTV [1:4],
  input  logic [15:0] devVECT  [1:4],
  output logic        busACKO,
  output logic [15:0] busVECT,
  output logic        busTMO
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  gdev_q, gdev_d, gbr_q, gbr_d, win_dev, win_br;
  logic        tmo_q, tmo_d, hi_any, lo_any, hi_m, lo_m, found, gnt_v;
  logic [15:0] vect_q, vect_d, gnt_vect;
  // Winner search: high class beats low class, higher BR first, then lowest device index
  always_comb begin
    hi_any  = 1'b0;
    lo_any  = 1'b0;
    found   = 1'b0;
    win_dev = 3'd1;
    win_br  = 3'd4;
    for (int d = 1; d <= 4; d++) begin
      hi_any = hi_any | devINTR[d][7] | devINTR[d][6];
      lo_any = lo_any | devINTR[d][5] | devINTR[d][4];
    end
    hi_m = (busPI != 3'd0) && (statPIH == busPI) && hi_any;
    lo_m = !hi_m && (busPI != 3'd0) && (statPIL == busPI) && lo_any;
    for (int b = 7; b >= 4; b--)
      for (int d = 1; d <= 4; d++)
        if (!found && ((hi_m && b >= 6) || (lo_m && b <= 5)) && devINTR[d][b]) begin
          found   = 1'b1;
          win_dev = 3'(d);
          win_br  = 3'(b);
        end
  end
  // Only the latched granted device's strobe is observed
  always_comb begin
    gnt_v    = 1'b0;
    gnt_vect = 16'h0;
    for (int d = 1; d <= 4; d++)
      if (gdev_q == 3'(d)) begin
        gnt_v    = devVECTV[d];
        gnt_vect = devVECT[d];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      gdev_q  <= 3'd1;
      gbr_q   <= 3'd4;
      tmo_q   <= 1'b0;
      vect_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gdev_q  <= gdev_d;
      gbr_q   <= gbr_d;
      tmo_q   <= tmo_d;
      vect_q  <= vect_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    cnt_d   = cnt_q;
    gdev_d  = gdev_q;
    gbr_d   = gbr_q;
    tmo_d   = tmo_q;
    vect_d  = vect_q;
    case (state_q)
      IDLE: if (busACKI && found) begin
        state_d = GRANT;
        cnt_d   = 8'd0;
        gdev_d  = win_dev;
        gbr_d   = win_br;
      end
      GRANT: begin
        cnt_d = cnt_q + 8'd1;
        if (gnt_v) begin
          state_d = DONE;
          tmo_d   = 1'b0;
          vect_d  = gnt_vect;
        end else if (cnt_d == 8'(TIMEOUT)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          vect_d  = 16'h0;
        end else
          state_d = GRANT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busACKO = (state_q == DONE);
    busTMO  = (state_q == DONE) && tmo_q;
    busVECT = vect_q;
    for (int d = 1; d <= 4; d++)
      for (int b = 4; b <= 7; b++)
        devACKO[d][b] = (state_q == GRANT) && (gdev_q == 3'(d)) && (gbr_q == 3'(b));
  end
endmodule

// File: tb/tb_uba_intack.sv
// tb_uba_intack: scoreboard bench for uba_intack with TIMEOUT=4
module tb_uba_intack;
  logic        clk = 1'b0;
  logic        rst, busACKI, busACKO, busTMO;
  logic [2:0]  busPI, statPIH, statPIL;
  logic [7:4]  devINTR  [1:4];
  logic [7:4]  devACKO  [1:4];
  logic        devVECTV [1:4];
  logic [15:0] devVECT  [1:4];
  logic [15:0] busVECT, acks;
  logic [16:0] sb [$];
  int          checks = 0, failures = 0;

  uba_intack #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .busACKI(busACKI), .busPI(busPI),
    .statPIH(statPIH), .statPIL(statPIL), .devINTR(devINTR), .devACKO(devACKO),
    .devVECTV(devVECTV), .devVECT(devVECT), .busACKO(busACKO),
    .busVECT(busVECT), .busTMO(busTMO)
  );

  always #5 clk = ~clk;
  always_comb acks = {devACKO[4], devACKO[3], devACKO[2], devACKO[1]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ea(input int d, input int b);
    return (d == 0) ? 16'h0 : 16'h1 << ((d - 1) * 4 + b - 4);
  endfunction

  always @(negedge clk)
    if (busACKO) begin
      if (sb.size() == 0) check("spurious_ack", 32'd1, 32'd0);
      else check("ack_resp", {15'd0, busTMO, busVECT}, {15'd0, sb.pop_front()});
    end

  task automatic do_ack(input logic [2:0] pi, input logic [15:0] exp, input string tag);
    busACKI = 1'b1;
    busPI   = pi;
    @(negedge clk);
    busACKI = 1'b0;
    busPI   = 3'd0;
    check(tag, acks, exp);
  endtask

  task automatic strobe(input int d, input logic [15:0] v);
    devVECTV[d] = 1'b1;
    devVECT[d]  = v;
    sb.push_back({1'b0, v});
    @(negedge clk);
    devVECTV[d] = 1'b0;
    check("strobe_ack", busACKO, 1'b1);
    check("strobe_acko_clr", acks, 16'h0);
    @(negedge clk);
  endtask

  task automatic clr_intr();
    for (int d = 1; d <= 4; d++) devINTR[d] = 4'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; busACKI = 1'b0; busPI = 3'd0; statPIH = 3'd3; statPIL = 3'd5;
    for (int d = 1; d <= 4; d++) begin
      devINTR[d] = 4'b0; devVECTV[d] = 1'b0; devVECT[d] = 16'h0;
    end
    repeat (2) @(negedge clk);
    check("rst_acko", acks, 16'h0);
    check("rst_busacko", busACKO, 1'b0);
    check("rst_tmo", busTMO, 1'b0);
    check("rst_vect", busVECT, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    // high match: dev2 BR6 over dev1 BR4
    devINTR[2] = 4'b0100; devINTR[1] = 4'b0001;
    do_ack(3'd3, ea(2, 6), "hi_grant");
    strobe(2, 16'o254);
    check("vect_hold", busVECT, 16'o254);
    // low match; request drop and a foreign strobe do not end the cycle
    do_ack(3'd5, ea(1, 4), "lo_grant");
    devINTR[1] = 4'b0; devVECTV[2] = 1'b1; devVECT[2] = 16'h1111;
    @(negedge clk);
    devVECTV[2] = 1'b0;
    check("foreign_vv_acko", acks, ea(1, 4));
    check("foreign_vv_busacko", busACKO, 1'b0);
    strobe(1, 16'h0abc);
    // equal PI levels: high class wins
    statPIH = 3'd4; statPIL = 3'd4; clr_intr();
    devINTR[3] = 4'b1000; devINTR[1] = 4'b0010;
    do_ack(3'd4, ea(3, 7), "tie_hi");
    strobe(3, 16'h0333);
    clr_intr(); devINTR[1] = 4'b0100; devINTR[4] = 4'b0100;
    do_ack(3'd4, ea(1, 6), "low_index");
    strobe(1, 16'h0111);
    clr_intr(); devINTR[1] = 4'b0100; devINTR[4] = 4'b1000;
    do_ack(3'd4, ea(4, 7), "br7_over_br6");
    strobe(4, 16'h0444);
    // timeout after 4 counts
    statPIH = 3'd3; statPIL = 3'd5; clr_intr(); devINTR[2] = 4'b0100;
    do_ack(3'd3, ea(2, 6), "tmo_grant");
    sb.push_back({1'b1, 16'h0});
    repeat (3) begin
      @(negedge clk);
      check("tmo_wait_busacko", busACKO, 1'b0);
      check("tmo_wait_acko", acks, ea(2, 6));
    end
    @(negedge clk);
    check("tmo_busacko", busACKO, 1'b1);
    check("tmo_flag", busTMO, 1'b1);
    check("tmo_vect", busVECT, 16'h0);
    check("tmo_acko", acks, 16'h0);
    @(negedge clk);
    check("tmo_pulse_len", busACKO, 1'b0);
    // strobe on the timeout cycle wins
    do_ack(3'd3, ea(2, 6), "race_grant");
    repeat (3) @(negedge clk);
    strobe(2, 16'h0777);
    // no match cases
    do_ack(3'd2, 16'h0, "pi_nomatch");
    do_ack(3'd0, 16'h0, "pi_zero");
    clr_intr();
    do_ack(3'd3, 16'h0, "no_request");
    repeat (2) @(negedge clk);
    check("nomatch_acko", acks, 16'h0);
    // second acknowledge during GRANT is dropped; grant latched
    devINTR[2] = 4'b0100;
    do_ack(3'd3, ea(2, 6), "grant_again");
    devINTR[2] = 4'b0; devINTR[4] = 4'b1000;
    do_ack(3'd3, ea(2, 6), "ack_in_grant");
    strobe(2, 16'h0222);
    check("no_queue", acks, 16'h0);
    // reset mid-GRANT
    clr_intr(); devINTR[2] = 4'b0100;
    do_ack(3'd3, ea(2, 6), "pre_rst_grant");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_acko", acks, 16'h0);
    check("midrst_busacko", busACKO, 1'b0);
    check("midrst_vect", busVECT, 16'h0);
    check("midrst_tmo", busTMO, 1'b0);
    do_ack(3'd3, ea(2, 6), "post_rst_grant");
    // completion with busACKI presented during DONE
    devVECTV[2] = 1'b1; devVECT[2] = 16'h0abc;
    sb.push_back({1'b0, 16'h0abc});
    @(negedge clk);
    devVECTV[2] = 1'b0;
    check("post_rst_busacko", busACKO, 1'b1);
    busACKI = 1'b1; busPI = 3'd3;
    @(negedge clk);
    busACKI = 1'b0; busPI = 3'd0;
    check("done_ack_ignored", acks, 16'h0);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uba_intack.md
UBA_INTACK -- requirements
Module: uba_intack

Interface
REQ-001 Parameter TIMEOUT, default 63, is the maximum number of cycles to wait for a device vector (legal range 1..255).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 busACKI  input  1  one-cycle pulse: CPU interrupt-acknowledge (vector read) request.
REQ-005 busPI  input  3  PI level being acknowledged, 1..7; 0 means none.
REQ-006 statPIH  input  3  PI level assigned to BR7/BR6 requests, from UBA status register.
REQ-007 statPIL  input  3  PI level assigned to BR5/BR4 requests, from UBA status register.
REQ-008 devINTR[1:4]  input  4 each [7:4]  per-device bus-request lines BR7..BR4.
REQ-009 devACKO[1:4]  output  4 each [7:4]  per-device grant, at most one bit asserted across all devices.
REQ-010 devVECTV[1:4]  input  1 each  device vector-valid strobe.
REQ-011 devVECT[1:4]  input  16 each  device interrupt vector.
REQ-012 busACKO  output  1  one-cycle response-complete pulse to the IO bridge.
REQ-013 busVECT  output  16  vector returned with busACKO; held until the next busACKO.
REQ-014 busTMO  output  1  qualifies busACKO: no device supplied a vector.

Function
REQ-015 The state machine SHALL have states IDLE, GRANT, DONE; reset and all undefined encodings go to IDLE.
REQ-016 In IDLE, a busACKI with busPI≠0 SHALL be a high match if statPIH==busPI and any device asserts BR7 or BR6.
REQ-017 Otherwise it SHALL be a low match if statPIL==busPI and any device asserts BR5 or BR4.
REQ-018 With no match, busACKI SHALL be ignored: no grant, no busACKO, stay in IDLE, so another UBA can answer.
REQ-019 When statPIH==statPIL and both classes are pending, the high class SHALL win.
REQ-020 Winner selection within the matched class: BR7 over BR6 (high), BR5 over BR4 (low); between devices, lowest index wins at equal BR.
REQ-021 Winner device/BR SHALL be latched at the busACKI edge; later changes on devINTR do not alter the grant.
REQ-022 Grant latency: busACKI sampled in cycle N drives the winner's devACKO bit high from cycle N+1, and the state is GRANT.
REQ-023 In GRANT, devACKO SHALL be held and an 8-bit wait counter, cleared on entry, SHALL increment every cycle.
REQ-024 In GRANT, devVECTV from the granted device SHALL capture its devVECT; the next cycle is DONE with busACKO=1, busTMO=0, and devACKO cleared.
REQ-025 devVECTV from non-granted devices SHALL be ignored at all times.
REQ-026 If the counter reaches TIMEOUT without a valid strobe, the block SHALL go to DONE with busACKO=1, busTMO=1, busVECT=0, and devACKO cleared.
REQ-027 If valid and timeout occur in the same cycle, valid wins (busTMO=0).
REQ-028 The granted device dropping its request during GRANT SHALL NOT end the cycle; only valid or timeout ends it.
REQ-029 DONE SHALL last exactly one cycle, then return to IDLE; busACKO and busTMO are high only in DONE.
REQ-030 busACKI arriving outside IDLE (including in DONE) SHALL be ignored; no queuing.
REQ-031 busVECT SHALL keep its last value outside DONE.

Reset
REQ-032 During rst: state=IDLE, all devACKO=0, busACKO=0, busTMO=0, busVECT=0, counter=0.
REQ-033 rst asserted mid-GRANT SHALL deassert devACKO at that edge; no busACKO is produced for the aborted cycle.

Verification
REQ-034 Setup: statPIH=3, statPIL=5, dev2 BR6 and dev1 BR4 pending. Stimulus: busACKI, busPI=3. Response: devACKO[2][6]=1 at N+1. Then dev2 devVECTV with 0o254: busACKO one cycle with busVECT=0o254 and busTMO=0.
REQ-035 Setup: statPIH=statPIL=4, dev3 BR7 and dev1 BR5 pending. Response: dev3 BR7 granted. Separately, with dev1 BR6 and dev4 BR6 pending, dev1 is granted.
REQ-036 Setup: TIMEOUT=4, granted device never strobes. Response: busACKO with busTMO=1 and busVECT=0 exactly when the counter reaches 4; devACKO is low from that cycle.
REQ-037 Stimulus: busPI=2 with statPIH=3, statPIL=5; then busPI=0. Response: no grant and no busACKO in both cases. A second busACKI during GRANT is also ignored.
REQ-038 Stimulus: rst during GRANT, followed by a fresh busACKI. Response: outputs at reset values; the new acknowledge completes normally with correct latency.
